seq_imul: RTL and testbench
===========================

Name: seq_imul

Overview:
- Multi-cycle integer multiplier for the MiniAlu datapath.
- Replaces the single-cycle combinational IMUL/IMUL2 path with a parametrised shift-add engine that retires DIGIT_BITS multiplier bits per clock.
- Uses a start/busy/done handshake so the control unit can stall on a multiply.
- Returns the full 2*WIDTH product, split into a bottom and a top half for two writebacks to the register RAM.

Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of DIGIT_BITS and at least 4.
- DIGIT_BITS, 2: multiplier bits consumed per iteration. Legal values are 1, 2 and 4. Iteration count N = WIDTH/DIGIT_BITS.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset. Low clears all state immediately, independent of Clock.
- iStart  in  1  request a multiply; sampled on a rising edge.
- iA  in  WIDTH  multiplicand; sampled with iStart.
- iB  in  WIDTH  multiplier; sampled with iStart.
- iSigned  in  1  1 = two's-complement operands; sampled with iStart.
- oBusy  out  1  high while an operation is in progress.
- oDone  out  1  one-cycle pulse when the product is valid.
- oResultBot  out  WIDTH  product bits [WIDTH-1:0].
- oResultTop  out  WIDTH  product bits [2*WIDTH-1:WIDTH].

Behaviour:
- Reset low (asynchronous):
  - state = IDLE; iteration counter = 0.
  - oBusy = 0, oDone = 0, oResultBot = 0, oResultTop = 0.
  - Multiplicand, multiplier and accumulator registers cleared.
- States:
  - IDLE: oBusy = 0. iStart = 1 at an edge: latch operands, clear the accumulator, counter = N, go to RUN.
  - RUN: oBusy = 1. Each edge:
    - accumulator += (multiplier[DIGIT_BITS-1:0] * multiplicand) << shift;
    - multiplier >>= DIGIT_BITS; shift += DIGIT_BITS; counter -= 1.
    - When the counter reaches 0, apply the sign fix-up, load oResultBot/oResultTop and go to DONE.
  - DONE: oDone = 1, oBusy = 0 for exactly one cycle, then IDLE. iStart = 1 at the DONE edge is accepted exactly as in IDLE (back-to-back operation).
- Latency:
  - Start sampled at edge E0; edges E1..EN iterate.
  - oDone is high from EN to EN+1, and oResult* are valid from EN.
  - Default parameters: N = 8, so the result appears 8 cycles after the start edge.
- iStart while in RUN: ignored. Operands and result are not disturbed, and no request is queued.
- Result hold: oResultBot/oResultTop hold their last product until the next completion. They do not change during RUN.
- Width rules:
  - Accumulator is 2*WIDTH bits; partial products are unsigned and computed on magnitudes.
  - No overflow is possible. 0xFFFF * 0xFFFF = 0xFFFE0001 exactly.
- Zero operands: still take the full N iterations. There is no early termination.
- Reset mid-RUN: the operation is aborted, outputs go to their reset values, and no oDone is generated.

Optional Feature:
- Macro: SEQ_IMUL_SIGNED_EN.
- Defined:
  - With iSigned = 1 at start, the latched operands are replaced by their absolute values and the result sign = iA[MSB] XOR iB[MSB].
  - If that sign is 1, the final 2*WIDTH product is two's-complement negated before loading into the outputs.
  - Most-negative operand (0x8000 at WIDTH = 16): its magnitude is treated as an unsigned 2^(WIDTH-1). Example: 0x8000 * 0x8000 signed = 0x40000000.
- Not defined: iSigned is ignored, all operations are unsigned, and no abs/negate logic is synthesised.

Test Plan:
- Unsigned basic: defaults, iA = 3, iB = 5, iStart pulse -> oBusy high 8 cycles; oDone pulse at the 8th edge after start; Top = 0x0000, Bot = 0x000F.
- Full range: iA = 0xFFFF, iB = 0xFFFF -> Top = 0xFFFE, Bot = 0x0001. Repeat with DIGIT_BITS = 1 (16 cycles) and DIGIT_BITS = 4 (4 cycles); same result.
- Signed (SEQ_IMUL_SIGNED_EN): iA = 0xFFFD (-3), iB = 5, iSigned = 1 -> Top = 0xFFFF, Bot = 0xFFF1. Same operands with iSigned = 0 -> 0x0004FFF1.
- Busy collision: start 7*9, assert iStart with iA = 2, iB = 2 at cycle 3 of RUN -> ignored; result 0x0000003F, single oDone pulse.
- Back-to-back: iStart held high with 2*3, then 4*4 presented at the DONE edge -> first oDone gives 6; second oDone exactly 8 cycles later gives 16; no IDLE cycle in between.
- Reset mid-op: start 0x1234*0x10, drop Reset at cycle 4 -> all outputs 0 immediately, asynchronously. Release Reset -> IDLE, no oDone; a fresh 0x1234*0x10 completes with 0x00012340.

Source files
------------

// File: rtl/seq_imul.sv
// seq_imul: shift-add integer multiplier that retires DIGIT_BITS multiplier bits per clock.
// Define SEQ_IMUL_SIGNED_EN to add two's-complement operation selected by iSigned.
module seq_imul #(
  parameter int WIDTH      = 16,
  parameter int DIGIT_BITS = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iSigned,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResultBot,
  output logic [WIDTH-1:0] oResultTop
);

  localparam int N     = WIDTH / DIGIT_BITS;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(N + 1);
  localparam int SH_W  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    result;
  logic [CNT_W-1:0] cnt;
  logic [SH_W-1:0]  shift;

`ifdef SEQ_IMUL_SIGNED_EN
  logic neg;

  // The most-negative value maps onto itself, which read unsigned is exactly 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] negate(input logic [PW-1:0] v);
    return ~v + PW'(1);
  endfunction
`else
  logic unused_signed;
  assign unused_signed = iSigned;
`endif

  always_comb begin
    pp       = (PW'(mplier[DIGIT_BITS-1:0]) * PW'(mcand)) << shift;
    acc_next = acc + pp;
`ifdef SEQ_IMUL_SIGNED_EN
    result   = neg ? negate(acc_next) : acc_next;
`else
    result   = acc_next;
`endif
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oResultBot <= '0;
      oResultTop <= '0;
`ifdef SEQ_IMUL_SIGNED_EN
      neg        <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
        IDLE, DONE: begin
          oDone <= 1'b0;
          state <= IDLE;
          if (iStart) begin
`ifdef SEQ_IMUL_SIGNED_EN
            if (iSigned) begin
              mcand  <= abs_mag(iA);
              mplier <= abs_mag(iB);
              neg    <= iA[WIDTH-1] ^ iB[WIDTH-1];
            end else begin
              mcand  <= iA;
              mplier <= iB;
              neg    <= 1'b0;
            end
`else
            mcand  <= iA;
            mplier <= iB;
`endif
            acc   <= '0;
            shift <= '0;
            cnt   <= CNT_W'(N);
            oBusy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> DIGIT_BITS;
          shift  <= shift + SH_W'(DIGIT_BITS);
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            oResultBot <= result[WIDTH-1:0];
            oResultTop <= result[PW-1:WIDTH];
            oBusy      <= 1'b0;
            oDone      <= 1'b1;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_imul.sv
// tb_seq_imul: directed bench for seq_imul at DIGIT_BITS 2, 1 and 4 against a timeline model.
module tb_seq_imul;

  localparam int W  = 16;
  localparam int NI = 3;

`ifdef SEQ_IMUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic          Clock;
  logic          Reset;
  logic          iStart;
  logic          iSigned;
  logic [W-1:0]  iA;
  logic [W-1:0]  iB;
  logic [NI-1:0] busy_w;
  logic [NI-1:0] done_w;
  logic [W-1:0]  bot_w [NI];
  logic [W-1:0]  top_w [NI];

  seq_imul #(.WIDTH(W), .DIGIT_BITS(2)) u_d2 (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iA(iA), .iB(iB), .iSigned(iSigned),
    .oBusy(busy_w[0]), .oDone(done_w[0]), .oResultBot(bot_w[0]), .oResultTop(top_w[0]));

  seq_imul #(.WIDTH(W), .DIGIT_BITS(1)) u_d1 (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iA(iA), .iB(iB), .iSigned(iSigned),
    .oBusy(busy_w[1]), .oDone(done_w[1]), .oResultBot(bot_w[1]), .oResultTop(top_w[1]));

  seq_imul #(.WIDTH(W), .DIGIT_BITS(4)) u_d4 (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iA(iA), .iB(iB), .iSigned(iSigned),
    .oBusy(busy_w[2]), .oDone(done_w[2]), .oResultBot(bot_w[2]), .oResultTop(top_w[2]));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          m_start [NI];
  int          m_done  [NI];
  logic [31:0] m_pend  [NI];
  logic [31:0] m_res   [NI];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int iters(input int k);
    case (k)
      0:       return 8;
      1:       return 16;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sg);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (SIGNED_EN && sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    p = sa * sb;
    return p[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Timeline model: an op started at edge s is busy until edge s+N, where the product lands.
  always @(posedge Clock) begin
    for (int k = 0; k < NI; k++) begin
      if (!Reset) begin
        m_start[k] <= -100;
        m_done[k]  <= -100;
        m_pend[k]  <= '0;
        m_res[k]   <= '0;
      end else begin
        if (cyc == m_done[k]) m_res[k] <= m_pend[k];
        if (iStart && cyc > m_done[k]) begin
          m_start[k] <= cyc;
          m_done[k]  <= cyc + iters(k);
          m_pend[k]  <= model_prod(iA, iB, iSigned);
        end
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge Clock) begin
    int t;
    t = cyc - 1;
    for (int k = 0; k < NI; k++) begin
      if (!Reset) begin
        chk($sformatf("rst_busy[%0d]", k), 32'(busy_w[k]), 32'd0);
        chk($sformatf("rst_done[%0d]", k), 32'(done_w[k]), 32'd0);
        chk($sformatf("rst_res[%0d]", k), {top_w[k], bot_w[k]}, 32'd0);
      end else begin
        chk($sformatf("busy[%0d]@%0d", k, t), 32'(busy_w[k]),
            32'((t >= m_start[k]) && (t < m_done[k])));
        chk($sformatf("done[%0d]@%0d", k, t), 32'(done_w[k]), 32'(t == m_done[k]));
        chk($sformatf("res[%0d]@%0d", k, t), {top_w[k], bot_w[k]}, m_res[k]);
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                          output int s);
    @(negedge Clock);
    iA      = a;
    iB      = b;
    iSigned = sg;
    iStart  = 1'b1;
    @(negedge Clock);
    iStart  = 1'b0;
    s = cyc - 1;
  endtask

  task automatic wait_done(output int td);
    td = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (done_w[0]) begin
        td = cyc - 1;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL done_timeout: got no oDone within 40 cycles, required one");
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock);
      if (done_w[0]) n++;
    end
  endtask

  task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sg, input logic [31:0] exp);
    int s, td;
    start_op(a, b, sg, s);
    wait_done(td);
    chk({name, "_latency"}, 32'(td - s), 32'd8);
    chk({name, "_result"}, {top_w[0], bot_w[0]}, exp);
    repeat (20) @(negedge Clock);
  endtask

  initial begin
    int s, td, td2, n;
    Reset   = 1'b0;
    iStart  = 1'b0;
    iSigned = 1'b0;
    iA      = '0;
    iB      = '0;
    repeat (3) @(posedge Clock);
    #3 Reset = 1'b1;
    @(negedge Clock);
    chk("reset_busy", 32'(busy_w[0]), 32'd0);
    chk("reset_done", 32'(done_w[0]), 32'd0);
    chk("reset_bot", 32'(bot_w[0]), 32'd0);
    chk("reset_top", 32'(top_w[0]), 32'd0);

    run_one("basic", 16'd3, 16'd5, 1'b0, 32'h0000_000F);

    start_op(16'hFFFF, 16'hFFFF, 1'b0, s);
    wait_done(td);
    chk("full_d2_latency", 32'(td - s), 32'd8);
    chk("full_d2", {top_w[0], bot_w[0]}, 32'hFFFE_0001);
    repeat (10) @(negedge Clock);
    chk("full_d1", {top_w[1], bot_w[1]}, 32'hFFFE_0001);
    chk("full_d4", {top_w[2], bot_w[2]}, 32'hFFFE_0001);
    repeat (20) @(negedge Clock);

`ifdef SEQ_IMUL_SIGNED_EN
    run_one("signed_neg", 16'hFFFD, 16'd5, 1'b1, 32'hFFFF_FFF1);
`else
    run_one("signed_ignored", 16'hFFFD, 16'd5, 1'b1, 32'h0004_FFF1);
`endif
    run_one("unsigned_fffd", 16'hFFFD, 16'd5, 1'b0, 32'h0004_FFF1);
    run_one("most_neg", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    run_one("zero", 16'h0000, 16'hABCD, 1'b0, 32'h0000_0000);

    // Busy collision: a request during RUN must not disturb the running multiply.
    start_op(16'd7, 16'd9, 1'b0, s);
    repeat (2) @(negedge Clock);
    iA     = 16'd2;
    iB     = 16'd2;
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    wait_done(td);
    chk("collision_latency", 32'(td - s), 32'd8);
    chk("collision_result", {top_w[0], bot_w[0]}, 32'h0000_003F);
    count_done(12, n);
    chk("collision_extra_done", 32'(n), 32'd0);
    repeat (10) @(negedge Clock);

    // Back-to-back: second request taken on the DONE edge.
    @(negedge Clock);
    iA      = 16'd2;
    iB      = 16'd3;
    iSigned = 1'b0;
    iStart  = 1'b1;
    wait_done(td);
    chk("b2b_first", {top_w[0], bot_w[0]}, 32'h0000_0006);
    iA = 16'd4;
    iB = 16'd4;
    @(negedge Clock);
    iStart = 1'b0;
    chk("b2b_no_idle_busy", 32'(busy_w[0]), 32'd1);
    wait_done(td2);
    chk("b2b_gap", 32'(td2 - td), 32'd9);
    chk("b2b_second", {top_w[0], bot_w[0]}, 32'h0000_0010);
    repeat (20) @(negedge Clock);

    // Asynchronous reset in the middle of a multiply.
    start_op(16'h1234, 16'h0010, 1'b0, s);
    repeat (4) @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_w[0]), 32'd0);
    chk("midrst_done", 32'(done_w[0]), 32'd0);
    chk("midrst_res", {top_w[0], bot_w[0]}, 32'd0);
    repeat (2) @(posedge Clock);
    #3 Reset = 1'b1;
    count_done(12, n);
    chk("midrst_no_done", 32'(n), 32'd0);
    run_one("after_rst", 16'h1234, 16'h0010, 1'b0, 32'h0001_2340);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
